corefifo_sync_ctrl: RTL and testbench
=====================================

COREFIFO_SYNC_CTRL -- requirements
Module: corefifo_sync_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 18: data width in bits, write and read side.
REQ-002 SHALL have parameter ADDR_W, default 4: address bits, so DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter AEMPTY_TH, default 2: almost-empty threshold in words.
REQ-004 SHALL have parameter AFULL_TH, default 14: almost-full threshold in words.
REQ-005 SHALL have port clk  in  1  single clock, rising edge.
REQ-006 SHALL have port reset_rclk_top  in  1  reset, synchronous to clk, active-high.
REQ-007 SHALL have port wr_en  in  1  write request, active-high.
REQ-008 SHALL have port din  in  WIDTH  write data.
REQ-009 SHALL have port rd_en  in  1  read request, driven by the downstream FWFT stage's fifo_rd_en.
REQ-010 SHALL have port dout  out  WIDTH  read data (feeds FWFT fifo_dout).
REQ-011 SHALL have port empty / aempty  out  1 each  feed FWFT fifo_empty / fifo_aempty.
REQ-012 SHALL have port full / afull  out  1 each  write-side status.
REQ-013 SHALL have port memraddr  out  ADDR_W  current read address (feeds FWFT fifo_MEMRADDR).
REQ-014 SHALL have port count  out  ADDR_W+1  words stored, 0..DEPTH.

Function
REQ-015 SHALL keep wptr, rptr of ADDR_W+1 bits, MSB a wrap bit; RAM address = low ADDR_W bits; both wrap naturally modulo 2*DEPTH.
REQ-016 SHALL accept a write (wr_acc) when wr_en=1 and full=0: RAM[wptr] <= din, wptr+1 at that edge.
REQ-017 SHALL accept a read (rd_acc) when rd_en=1 and empty=0: dout <= RAM[rptr], rptr+1 at that edge; read latency exactly 1 cycle.
REQ-018 SHALL hold dout unchanged in every cycle without rd_acc.
REQ-019 SHALL update count registered: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
REQ-020 SHALL derive empty=(count==0), full=(count==DEPTH), aempty=(count<=AEMPTY_TH), afull=(count>=AFULL_TH), all from the registered count, so flags change the cycle after the causing access.
REQ-021 SHALL drive memraddr = rptr[ADDR_W-1:0].
REQ-022 Full with wr_en and rd_en both high: read accepted, write rejected; count -> DEPTH-1.
REQ-023 Empty with wr_en and rd_en both high: write accepted, read rejected; dout held; count -> 1.
REQ-024 Neither flag set, both requests high: both accepted; count, empty, full unchanged.
REQ-025 A write into the address being read the same cycle SHALL NOT occur (guaranteed by count>0 for read, count<DEPTH for write).

Reset
REQ-026 On reset_rclk_top=1 at a clk edge: wptr=0, rptr=0, count=0, dout=0, empty=1, aempty=1, full=0, afull=0, memraddr=0.
REQ-027 Reset SHALL override simultaneous wr_en/rd_en; requests in the reset cycle are dropped.
REQ-028 RAM contents SHALL NOT be reset.

Configuration
REQ-029 Macro COREFIFO_OVF_UDF_EN defined: adds outputs overflow and underflow (1 bit each, registered, reset 0), overflow=1 for one cycle after wr_en=1 with full=1, underflow=1 for one cycle after rd_en=1 with empty=1.
REQ-030 Macro undefined: the two ports and their logic SHALL be absent; all other behaviour identical.

Structure
REQ-031 Package corefifo_pkg SHALL hold default WIDTH/ADDR_W/threshold constants and a ptr width function (ADDR_W+1).
REQ-032 RAM SHALL be sub-module corefifo_ram: simple dual-port, one write port, one synchronous read port with read enable, no reset.

Verification (WIDTH=8, ADDR_W=4, AEMPTY_TH=2, AFULL_TH=14)
REQ-033 Reset then idle -> empty=1, aempty=1, full=0, count=0, dout=0x00.
REQ-034 Write 0x11,0x22,0x33 then rd_en 3 cycles -> dout 0x11,0x22,0x33 each one cycle after its read; empty=1 the cycle after third read; aempty deasserts at count=3.
REQ-035 16 writes 0x00..0x0F -> afull=1 after 14th, full=1 after 16th; 17th write 0xAA dropped; 16 reads return 0x00..0x0F, no 0xAA.
REQ-036 Full, wr_en=rd_en=1 -> count 16->15, dout=oldest word, full=0 next cycle; empty, wr_en=rd_en=1 -> count 0->1, dout held.
REQ-037 40 interleaved write/read pairs crossing pointer wrap -> data order preserved, memraddr steps 0..15 and wraps to 0.
REQ-038 reset_rclk_top=1 mid-traffic with count=7 -> next cycle all REQ-026 values; with COREFIFO_OVF_UDF_EN, rd_en on empty -> underflow pulse one cycle.

Source files
------------

// File: rtl/corefifo_pkg.sv
// corefifo shared constants and helpers.
// Optional overflow/underflow outputs: COREFIFO_OVF_UDF_EN.
package corefifo_pkg;

  localparam int DEF_WIDTH     = 18;
  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_AEMPTY_TH = 2;
  localparam int DEF_AFULL_TH  = 14;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/corefifo_sync_ctrl_if.sv
// corefifo_sync_ctrl user-side bus.
// COREFIFO_OVF_UDF_EN adds overflow/underflow.
interface corefifo_sync_ctrl_if
  import corefifo_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              wr_en;
  logic [WIDTH-1:0]  din;
  logic              rd_en;
  logic [WIDTH-1:0]  dout;
  logic              empty;
  logic              aempty;
  logic              full;
  logic              afull;
  logic [ADDR_W-1:0] memraddr;
  logic [ADDR_W:0]   count;
`ifdef COREFIFO_OVF_UDF_EN
  logic              overflow;
  logic              underflow;
`endif

  modport master (
    output wr_en, din, rd_en,
    input  dout, empty, aempty, full, afull,
    input  memraddr, count
`ifdef COREFIFO_OVF_UDF_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, empty, aempty, full, afull,
    output memraddr, count
`ifdef COREFIFO_OVF_UDF_EN
    , output overflow, underflow
`endif
  );

endinterface

// File: rtl/corefifo_ram.sv
// Simple dual-port RAM: one write port,
// one registered read port with enable, no reset.
module corefifo_ram
  import corefifo_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/corefifo_sync_ctrl.sv
// Single-clock FIFO controller with registered count flags.
// COREFIFO_OVF_UDF_EN adds overflow/underflow pulses.
module corefifo_sync_ctrl
  import corefifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH,
  parameter int AFULL_TH  = DEF_AFULL_TH
) (
  input logic clk,
  input logic reset_rclk_top,
  corefifo_sync_ctrl_if.slave f
);

  localparam int PW    = ptr_w(ADDR_W);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AE_C    = PW'(AEMPTY_TH);
  localparam logic [PW-1:0] AF_C    = PW'(AFULL_TH);

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    count_q, count_d;
  logic             vld_q, vld_d;
  logic             wr_acc, rd_acc;
  logic             empty, full;
  logic [WIDTH-1:0] ram_rdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  always_comb begin
    wr_acc  = f.wr_en && !full && !reset_rclk_top;
    rd_acc  = f.rd_en && !empty && !reset_rclk_top;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    vld_d   = vld_q;
    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) begin
      rptr_d = rptr_q + 1'b1;
      vld_d  = 1'b1;
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_rclk_top) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  corefifo_ram #(
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wptr_q[ADDR_W-1:0]),
    .wdata(f.din),
    .re   (rd_acc),
    .raddr(rptr_q[ADDR_W-1:0]),
    .rdata(ram_rdata)
  );

  // RAM has no reset, so dout reads zero until the first read lands.
  assign f.dout     = vld_q ? ram_rdata : '0;
  assign f.empty    = empty;
  assign f.full     = full;
  assign f.aempty   = (count_q <= AE_C);
  assign f.afull    = (count_q >= AF_C);
  assign f.memraddr = rptr_q[ADDR_W-1:0];
  assign f.count    = count_q;

`ifdef COREFIFO_OVF_UDF_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = f.wr_en && full;
    udf_d = f.rd_en && empty;
  end

  always_ff @(posedge clk) begin
    if (reset_rclk_top) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign f.overflow  = ovf_q;
  assign f.underflow = udf_q;
`endif

endmodule

// File: tb/tb_corefifo_sync_ctrl.sv
// Directed self-checking bench for corefifo_sync_ctrl.
// Underflow pulse checked when COREFIFO_OVF_UDF_EN is defined.
module tb_corefifo_sync_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_rptr = 0;

  always #5 clk = ~clk;

  corefifo_sync_ctrl_if #(.WIDTH(8), .ADDR_W(4)) bus ();

  corefifo_sync_ctrl #(
    .WIDTH    (8),
    .ADDR_W   (4),
    .AEMPTY_TH(2),
    .AFULL_TH (14)
  ) dut (
    .clk           (clk),
    .reset_rclk_top(rst),
    .f             (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.din   = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic rd();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.din = 8'hC3;
    tick();
    tick();
    rst = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    tick();
    n_chk++;
    if (bus.count !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_count got %0d want 0", bus.count);
    end
    n_chk++;
    if ({bus.empty, bus.aempty, bus.full, bus.afull} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 1100",
        {bus.empty, bus.aempty, bus.full, bus.afull});
    end
    n_chk++;
    if (bus.dout !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_dout got %h want 00", bus.dout);
    end
    n_chk++;
    if (bus.memraddr !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_raddr got %0d want 0", bus.memraddr);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp [3];
    exp = '{8'h11, 8'h22, 8'h33};
    wr(8'h11);
    wr(8'h22);
    n_chk++;
    if (bus.aempty !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_aempty2 got %b want 1", bus.aempty);
    end
    wr(8'h33);
    n_chk++;
    if (bus.aempty !== 1'b0 || bus.count !== 5'd3) begin
      n_fail++;
      $display("FAIL basic_aempty3 got ae=%b cnt=%0d want 0/3",
        bus.aempty, bus.count);
    end
    bus.rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (bus.dout !== exp[i]) begin
        n_fail++;
        $display("FAIL basic_rd%0d got %h want %h", i, bus.dout, exp[i]);
      end
    end
    bus.rd_en = 1'b0;
    exp_rptr += 3;
    n_chk++;
    if (bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_empty got %b want 1", bus.empty);
    end
    tick();
    n_chk++;
    if (bus.dout !== 8'h33) begin
      n_fail++;
      $display("FAIL basic_hold got %h want 33", bus.dout);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      wr(8'(i));
      if (i == 12 || i == 13) begin
        n_chk++;
        if (bus.afull !== (i == 13)) begin
          n_fail++;
          $display("FAIL full_afull%0d got %b want %b",
            i + 1, bus.afull, (i == 13));
        end
      end
      if (i == 14 || i == 15) begin
        n_chk++;
        if (bus.full !== (i == 15)) begin
          n_fail++;
          $display("FAIL full_full%0d got %b want %b",
            i + 1, bus.full, (i == 15));
        end
      end
    end
    wr(8'hAA);
    n_chk++;
    if (bus.count !== 5'd16) begin
      n_fail++;
      $display("FAIL full_drop got %0d want 16", bus.count);
    end
    bus.rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_chk++;
      if (bus.dout !== 8'(i)) begin
        n_fail++;
        $display("FAIL full_rd%0d got %h want %h", i, bus.dout, 8'(i));
      end
    end
    exp_rptr += 16;
    tick();
    bus.rd_en = 1'b0;
    n_chk++;
    if (bus.dout !== 8'h0F || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL full_noaa got %h e=%b want 0f e=1",
        bus.dout, bus.empty);
    end
  endtask

  task automatic test_both();
    for (int i = 0; i < 16; i++) wr(8'h40 + 8'(i));
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.din = 8'hEE;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    exp_rptr += 1;
    n_chk++;
    if (bus.count !== 5'd15 || bus.dout !== 8'h40 || bus.full !== 1'b0) begin
      n_fail++;
      $display("FAIL both_full got cnt=%0d d=%h f=%b want 15/40/0",
        bus.count, bus.dout, bus.full);
    end
    for (int i = 1; i < 16; i++) begin
      rd();
      n_chk++;
      if (bus.dout !== 8'h40 + 8'(i)) begin
        n_fail++;
        $display("FAIL both_drain%0d got %h want %h",
          i, bus.dout, 8'h40 + 8'(i));
      end
    end
    exp_rptr += 15;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.din = 8'h5A;
    tick();
    n_chk++;
    if (bus.count !== 5'd1 || bus.dout !== 8'h4F || bus.empty !== 1'b0) begin
      n_fail++;
      $display("FAIL both_empty got cnt=%0d d=%h e=%b want 1/4f/0",
        bus.count, bus.dout, bus.empty);
    end
    bus.din = 8'h5B;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    exp_rptr += 1;
    n_chk++;
    if (bus.count !== 5'd1 || bus.dout !== 8'h5A) begin
      n_fail++;
      $display("FAIL both_mid got cnt=%0d d=%h want 1/5a",
        bus.count, bus.dout);
    end
    rd();
    exp_rptr += 1;
    n_chk++;
    if (bus.dout !== 8'h5B || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL both_last got d=%h e=%b want 5b/1",
        bus.dout, bus.empty);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 40; i++) begin
      wr(8'h80 + 8'(i));
      rd();
      exp_rptr += 1;
      n_chk++;
      if (bus.dout !== 8'h80 + 8'(i) ||
          bus.memraddr !== 4'(exp_rptr)) begin
        n_fail++;
        $display("FAIL wrap%0d got d=%h ra=%0d want %h/%0d", i,
          bus.dout, bus.memraddr, 8'h80 + 8'(i), 4'(exp_rptr));
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) wr(8'h60 + 8'(i));
    n_chk++;
    if (bus.count !== 5'd7) begin
      n_fail++;
      $display("FAIL mid_count got %0d want 7", bus.count);
    end
    rst = 1'b1;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    tick();
    rst = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    exp_rptr = 0;
    n_chk++;
    if (bus.count !== 5'd0 || bus.dout !== 8'h00 || bus.memraddr !== 4'd0 ||
        {bus.empty, bus.aempty, bus.full, bus.afull} !== 4'b1100) begin
      n_fail++;
      $display("FAIL mid_reset got cnt=%0d d=%h ra=%0d fl=%b want 0/00/0/1100",
        bus.count, bus.dout, bus.memraddr,
        {bus.empty, bus.aempty, bus.full, bus.afull});
    end
`ifdef COREFIFO_OVF_UDF_EN
    rd();
    n_chk++;
    if (bus.underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL udf_pulse got %b want 1", bus.underflow);
    end
    tick();
    n_chk++;
    if (bus.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL udf_clear got %b want 0", bus.underflow);
    end
`endif
    wr(8'h77);
    rd();
    n_chk++;
    if (bus.dout !== 8'h77 || bus.memraddr !== 4'd1) begin
      n_fail++;
      $display("FAIL mid_after got d=%h ra=%0d want 77/1",
        bus.dout, bus.memraddr);
    end
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = 8'h00;
    test_reset();
    test_basic();
    test_full();
    test_both();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
